// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared FSM encodings and timing constants for the pe array sequencer
package pe_pkg;

  localparam int ST_W   = 2;
  localparam int RD_LAT = 1;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/vld_skew.sv
// rtl/vld_skew.sv - single-bit delay line; taps[d] is din delayed d+1 cycles
module vld_skew #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [DEPTH-1:0] taps
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

endmodule

// File: rtl/pe_array_seq.sv
// rtl/pe_array_seq.sv - operand fetch and skewed-valid sequencer for a ROWS x COLS pe array
module pe_array_seq
  import pe_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] k_len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_rd_addr,
  output logic [ROWS-1:0]   row_vld,
  output logic [COLS-1:0]   col_vld,
  output logic              pe_en,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH     = (ROWS > COLS) ? ROWS : COLS;
  localparam int DRAIN_LEN = ROWS + COLS;
  localparam int DW        = $clog2(DRAIN_LEN);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] k_len_q, a_base_q, b_base_q, k_q;
  logic [DW-1:0]     drain_q;
  logic [DEPTH-1:0]  taps;
  logic              feed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_len_q  <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      k_q      <= '0;
      drain_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start && (k_len != '0)) begin
            k_len_q  <= k_len;
            a_base_q <= a_base;
            b_base_q <= b_base;
            k_q      <= '0;
          end
        end
        ST_FEED: begin
          k_q     <= k_q + ADDR_W'(1);
          drain_q <= '0;
        end
        ST_DRAIN: drain_q <= drain_q + DW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (k_len == '0) ? ST_DONE : ST_FEED;
      ST_FEED:  if (k_q == k_len_q - ADDR_W'(1)) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == DW'(DRAIN_LEN - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Addresses wrap modulo 2^ADDR_W and are forced to zero outside FEED.
  assign feed      = (state_q == ST_FEED);
  assign a_rd_en   = feed;
  assign b_rd_en   = feed;
  assign a_rd_addr = feed ? (a_base_q + k_q) : '0;
  assign b_rd_addr = feed ? (b_base_q + k_q) : '0;
  assign busy      = (state_q == ST_FEED) || (state_q == ST_DRAIN);
  assign pe_en     = busy;
  assign done      = (state_q == ST_DONE);

  // taps[0] is the RAM-latency-aligned base valid; deeper taps give the skew.
  vld_skew #(.DEPTH(DEPTH)) u_skew (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (a_rd_en),
    .taps  (taps)
  );

  assign row_vld = taps[ROWS-1:0];
  assign col_vld = taps[COLS-1:0];

endmodule

// File: tb/tb_pe_array_seq.sv
// tb/tb_pe_array_seq.sv - randomized self-checking bench for pe_array_seq
module tb_pe_array_seq;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] k_len, a_base, b_base;
  logic              a_rd_en, b_rd_en;
  logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
  logic [ROWS-1:0]   row_vld;
  logic [COLS-1:0]   col_vld;
  logic              pe_en, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  // reference tile: start cycle, length, bases
  int  cyc = 0;
  bit  have = 0;
  int  t_s, t_k;
  logic [ADDR_W-1:0] t_a, t_b;

  always #5 clk = ~clk;

  pe_array_seq #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .a_base(a_base), .b_base(b_base),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
    .row_vld(row_vld), .col_vld(col_vld),
    .pe_en(pe_en), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int done_off(input int k);
    return (k == 0) ? 1 : k + ROWS + COLS + 1;
  endfunction

  function automatic bit model_idle(input int c);
    return !have || (c > t_s + done_off(t_k));
  endfunction

  task automatic check_outputs();
    int d;
    bit e_rd, e_busy, e_done;
    logic [ADDR_W-1:0] e_aa, e_ba;
    logic [ROWS-1:0] e_row;
    logic [COLS-1:0] e_col;
    e_rd = 0; e_busy = 0; e_done = 0; e_aa = '0; e_ba = '0; e_row = '0; e_col = '0;
    if (have) begin
      d = cyc - t_s;
      e_done = (d == done_off(t_k));
      if (t_k > 0) begin
        e_rd   = (d >= 1) && (d <= t_k);
        e_busy = (d >= 1) && (d <= t_k + ROWS + COLS);
        if (e_rd) begin
          e_aa = t_a + ADDR_W'(d - 1);
          e_ba = t_b + ADDR_W'(d - 1);
        end
        for (int i = 0; i < ROWS; i++) e_row[i] = (d >= 2 + i) && (d <= t_k + 1 + i);
        for (int j = 0; j < COLS; j++) e_col[j] = (d >= 2 + j) && (d <= t_k + 1 + j);
      end
    end
    check("a_rd_en",   32'(a_rd_en),   32'(e_rd));
    check("b_rd_en",   32'(b_rd_en),   32'(e_rd));
    check("a_rd_addr", 32'(a_rd_addr), 32'(e_aa));
    check("b_rd_addr", 32'(b_rd_addr), 32'(e_ba));
    check("row_vld",   32'(row_vld),   32'(e_row));
    check("col_vld",   32'(col_vld),   32'(e_col));
    check("pe_en",     32'(pe_en),     32'(e_busy));
    check("busy",      32'(busy),      32'(e_busy));
    check("done",      32'(done),      32'(e_done));
  endtask

  // Inputs apply to the current cycle; outputs are checked 1 time unit after the edge.
  task automatic step(input bit st, input int kl, input logic [ADDR_W-1:0] ab,
                      input logic [ADDR_W-1:0] bb);
    start = st; k_len = ADDR_W'(kl); a_base = ab; b_base = bb;
    @(posedge clk);
    if (st && model_idle(cyc)) begin
      have = 1; t_s = cyc; t_k = kl; t_a = ab; t_b = bb;
    end
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0);
  endtask

  initial begin
    rst_n = 1'b0; start = 0; k_len = '0; a_base = '0; b_base = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // basic tile with start re-pulses while busy/done, then a start right after done
    for (int c = 0; c < 30; c++)
      step(c == 0 || c == 2 || c == 6 || c == 12 || c == 13, 3, 8'h10, 8'h40);
    idle(2);

    // zero-length tile
    step(1, 0, 8'h33, 8'h44);
    idle(4);

    // address wrap
    step(1, 3, 8'hFE, 8'hFF);
    idle(14);

    // reset in the middle of a tile
    step(1, 3, 8'h10, 8'h40);
    idle(4);
    rst_n = 1'b0;
    have  = 0;
    #1;
    check_outputs();
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    check_outputs();
    step(1, 3, 8'h10, 8'h40);
    idle(14);

    // back-to-back k_len=1 tiles
    step(1, 1, 8'h05, 8'h06);
    idle(9);
    step(1, 1, 8'h07, 8'h08);
    idle(9);
    step(1, 1, 8'h09, 8'h0A);
    idle(12);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      int kl;
      kl = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      if ($urandom_range(0, 15) == 0) kl = int'($urandom_range(13, 40));
      step($urandom_range(0, 3) == 0, kl, ADDR_W'($urandom), ADDR_W'($urandom));
    end
    idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
